// File: rtl/mips32_state_dump.sv
// Post-HALT read-back engine: streams the register file, then a wrapped memory window,
// as valid/ready beats through a 2-entry output FIFO.
module mips32_state_dump #(
  parameter int REG_COUNT = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int DATA_W    = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              start,
  input  logic [ADDR_W-1:0] mem_base,
  input  logic [ADDR_W:0]   mem_len,
  output logic [4:0]        reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tag,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REG_RD = 2'd1;
  localparam logic [1:0] S_MEM_RD = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;
  localparam logic [4:0] REG_LAST = 5'(REG_COUNT - 1);

  logic [1:0]        state;
  logic              primed;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   mem_cnt;

  logic              inf_valid;
  logic              inf_tag;
  logic              inf_last;
  logic [ADDR_W-1:0] inf_index;

  logic [DATA_W-1:0] f_data  [2];
  logic [ADDR_W-1:0] f_index [2];
  logic              f_tag   [2];
  logic              f_last  [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic       pop;
  logic [2:0] load;
  logic       room;
  logic       issue;
  logic       reg_issue;
  logic       mem_issue;
  logic       reg_final;
  logic       mem_final;
  logic       issue_last;
  logic       abort;
  logic       last_accept;

  assign out_valid = (count != 2'd0);
  assign out_data  = f_data[rd_ptr];
  assign out_tag   = f_tag[rd_ptr];
  assign out_index = f_index[rd_ptr];
  assign out_last  = f_last[rd_ptr];
  assign busy      = (state != S_IDLE);

  // Occupancy is counted net of a beat leaving this cycle, so a steady stream sustains one beat per cycle.
  assign pop        = out_valid & out_ready;
  assign load       = {1'b0, count} - {2'b0, pop} + {2'b0, inf_valid};
  assign room       = (load < 3'd2);
  assign issue      = primed & room & ((state == S_REG_RD) | (state == S_MEM_RD));
  assign reg_issue  = issue & (state == S_REG_RD);
  assign mem_issue  = issue & (state == S_MEM_RD);
  assign reg_final  = (reg_rd_addr == REG_LAST);
  assign mem_final  = (mem_cnt == (len_q - (ADDR_W+1)'(1)));
  assign issue_last = (reg_issue & reg_final & (len_q == '0)) | (mem_issue & mem_final);
  assign abort      = busy & ~halted;
  assign last_accept = pop & out_last;
  assign mem_rd_en  = mem_issue;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state       <= S_IDLE;
      primed      <= 1'b0;
      len_q       <= '0;
      mem_cnt     <= '0;
      reg_rd_addr <= '0;
      mem_rd_addr <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      if (abort) begin
        state  <= S_IDLE;
        primed <= 1'b0;
        err    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && halted) begin
              state       <= S_REG_RD;
              primed      <= 1'b0;
              len_q       <= mem_len;
              mem_cnt     <= '0;
              reg_rd_addr <= '0;
              mem_rd_addr <= mem_base;
            end else if (start) begin
              err <= 1'b1;
            end
          end
          S_REG_RD: begin
            primed <= 1'b1;
            if (reg_issue) begin
              if (reg_final) state <= (len_q == '0) ? S_DRAIN : S_MEM_RD;
              else reg_rd_addr <= reg_rd_addr + 5'd1;
            end
          end
          S_MEM_RD: begin
            if (mem_issue) begin
              mem_cnt <= mem_cnt + (ADDR_W+1)'(1);
              if (mem_final) state <= S_DRAIN;
              else mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
            end
          end
          default: begin
            if (last_accept) begin
              state  <= S_IDLE;
              primed <= 1'b0;
              done   <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Read returns land in the FIFO one cycle after issue; abort discards both FIFO and in-flight read.
  always_ff @(posedge clk1) begin
    if (rst) begin
      inf_valid <= 1'b0;
      inf_tag   <= 1'b0;
      inf_last  <= 1'b0;
      inf_index <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        f_data[i]  <= '0;
        f_index[i] <= '0;
        f_tag[i]   <= 1'b0;
        f_last[i]  <= 1'b0;
      end
    end else if (abort) begin
      inf_valid <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      inf_valid <= issue;
      if (issue) begin
        inf_tag   <= (state == S_MEM_RD);
        inf_last  <= issue_last;
        inf_index <= mem_issue ? mem_rd_addr : ADDR_W'(reg_rd_addr);
      end
      if (inf_valid) begin
        f_data[wr_ptr]  <= inf_tag ? mem_rd_data : reg_rd_data;
        f_index[wr_ptr] <= inf_index;
        f_tag[wr_ptr]   <= inf_tag;
        f_last[wr_ptr]  <= inf_last;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inf_valid} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_mips32_state_dump.sv
// Self-checking bench for mips32_state_dump: a beat-queue model built from the dump rules,
// compared against the stream every cycle, plus literal expectations for directed scenarios.
module tb_mips32_state_dump;

  localparam int REG_COUNT = 32;
  localparam int MEM_DEPTH = 1024;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              tag;
    logic [ADDR_W-1:0] index;
    logic              last;
  } beat_t;

  logic              clk1;
  logic              rst;
  logic              halted;
  logic              start;
  logic [ADDR_W-1:0] mem_base;
  logic [ADDR_W:0]   mem_len;
  logic [4:0]        reg_rd_addr;
  logic [DATA_W-1:0] reg_rd_data;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_tag;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] mem  [MEM_DEPTH];

  beat_t exp_q[$];
  beat_t acc_log[$];
  bit    m_busy;
  bit    m_err;
  bit    m_done;
  bit    shown;
  bit    first_seen;
  int    cs;

  bit    chk_en;
  int    checks;
  int    errors;

  mips32_state_dump #(
    .REG_COUNT(REG_COUNT), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk1(clk1), .rst(rst), .halted(halted), .start(start),
    .mem_base(mem_base), .mem_len(mem_len),
    .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Register file and memory with one-cycle synchronous read.
  always @(posedge clk1) begin
    reg_rd_data <= regs[reg_rd_addr];
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Reference model: on an accepted start, the whole expected beat sequence is queued at once.
  always @(posedge clk1) begin
    if (rst) begin
      exp_q.delete();
      m_busy <= 1'b0;
      m_err  <= 1'b0;
      m_done <= 1'b0;
      shown  <= 1'b0;
    end else if (m_busy && !halted) begin
      exp_q.delete();
      m_busy <= 1'b0;
      m_err  <= 1'b1;
      m_done <= 1'b0;
      shown  <= 1'b0;
    end else begin
      m_err  <= 1'b0;
      m_done <= 1'b0;
      if (m_busy && out_valid && out_ready) begin
        acc_log.push_back('{data: out_data, tag: out_tag, index: out_index, last: out_last});
        if (exp_q.size() > 0) begin
          if (exp_q[0].last) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end
          void'(exp_q.pop_front());
        end
        shown <= 1'b0;
      end else if (out_valid) begin
        shown <= 1'b1;
      end
      if (out_valid) first_seen <= 1'b1;
      if (!m_busy && start) begin
        if (halted) begin
          m_busy     <= 1'b1;
          cs         <= 0;
          first_seen <= 1'b0;
          exp_q.delete();
          for (int k = 0; k < REG_COUNT; k++)
            exp_q.push_back('{data: regs[k], tag: 1'b0, index: ADDR_W'(k),
                              last: (k == REG_COUNT - 1) && (mem_len == 0)});
          for (int i = 0; i < int'(mem_len); i++)
            exp_q.push_back('{data: mem[(int'(mem_base) + i) % MEM_DEPTH], tag: 1'b1,
                              index: ADDR_W'((int'(mem_base) + i) % MEM_DEPTH),
                              last: (i == int'(mem_len) - 1)});
        end else begin
          m_err <= 1'b1;
        end
      end else if (m_busy) begin
        cs <= cs + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compareLoop();
    forever begin
      @(negedge clk1);
      if (chk_en) begin
        checkOutput("busy", 32'(busy), 32'(m_busy));
        checkOutput("err", 32'(err), 32'(m_err));
        checkOutput("done", 32'(done), 32'(m_done));
        if (exp_q.size() == 0) begin
          checkOutput("valid_when_empty", 32'(out_valid), 0);
        end else begin
          if (shown) checkOutput("valid_hold", 32'(out_valid), 1);
          if (!first_seen) checkOutput("first_beat_latency", 32'(out_valid), 32'(cs >= 3));
          if (out_valid) begin
            checkOutput("beat_data", out_data, exp_q[0].data);
            checkOutput("beat_tag", 32'(out_tag), 32'(exp_q[0].tag));
            checkOutput("beat_index", 32'(out_index), 32'(exp_q[0].index));
            checkOutput("beat_last", 32'(out_last), 32'(exp_q[0].last));
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input logic h, input logic rdy,
                               input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    @(negedge clk1);
    #1;
    start     = st;
    halted    = h;
    out_ready = rdy;
    mem_base  = base;
    mem_len   = len;
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1,0,1; 2: random ready plus stray starts
  task automatic runDump(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                         input int mode, output int cycles);
    logic [5:0] pat;
    pat = 6'b101001;
    applyStimulus(1'b1, 1'b1, 1'b1, base, len);
    cycles = -1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk1);
      #1;
      start = 1'b0;
      if (done) begin
        cycles = i;
        break;
      end
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = pat[i % 6];
      else out_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2 && i < 20 && $urandom_range(0, 3) == 0) start = 1'b1;
    end
    if (cycles < 0) checkOutput("done_timeout", 0, 1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_valid", 32'(out_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_data", out_data, 0);
    checkOutput("rst_tag", 32'(out_tag), 0);
    checkOutput("rst_index", 32'(out_index), 0);
    checkOutput("rst_last", 32'(out_last), 0);
    checkOutput("rst_mem_en", 32'(mem_rd_en), 0);
    checkOutput("rst_reg_addr", 32'(reg_rd_addr), 0);
    checkOutput("rst_mem_addr", 32'(mem_rd_addr), 0);
  endtask

  initial begin
    int cyc;
    int lb;
    logic [31:0] prog [9];
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
             32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    halted = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    mem_base = '0;
    mem_len = '0;
    for (int k = 0; k < REG_COUNT; k++) regs[k] = 32'(k);
    for (int a = 0; a < MEM_DEPTH; a++) mem[a] = $urandom;
    for (int a = 0; a < 9; a++) mem[a] = prog[a];
    fork
      compareLoop();
    join_none

    repeat (2) @(negedge clk1);
    #1;
    checkResetState();
    chk_en = 1'b1;
    rst = 1'b0;

    // Registers only.
    lb = acc_log.size();
    runDump(10'd0, 11'd0, 0, cyc);
    checkOutput("regs_cycles_to_done", 32'(cyc), 35);
    checkOutput("regs_beat_count", 32'(acc_log.size() - lb), 32);
    checkOutput("regs_beat5_data", acc_log[lb + 5].data, 32'd5);
    checkOutput("regs_last_index", 32'(acc_log[lb + 31].index), 31);
    checkOutput("regs_last_flag", 32'(acc_log[lb + 31].last), 1);

    // Registers plus the ADD program.
    lb = acc_log.size();
    runDump(10'd0, 11'd9, 0, cyc);
    checkOutput("prog_cycles_to_done", 32'(cyc), 44);
    checkOutput("prog_beat_count", 32'(acc_log.size() - lb), 41);
    checkOutput("prog_reg31_not_last", 32'(acc_log[lb + 31].last), 0);
    checkOutput("prog_first_mem_tag", 32'(acc_log[lb + 32].tag), 1);
    checkOutput("prog_first_mem_word", acc_log[lb + 32].data, 32'h2801000a);
    checkOutput("prog_final_word", acc_log[lb + 40].data, 32'hfc000000);
    checkOutput("prog_final_last", 32'(acc_log[lb + 40].last), 1);

    // Same dump under a stalling sink.
    lb = acc_log.size();
    runDump(10'd0, 11'd9, 1, cyc);
    checkOutput("stall_beat_count", 32'(acc_log.size() - lb), 41);
    checkOutput("stall_mem4_index", 32'(acc_log[lb + 36].index), 4);
    checkOutput("stall_final_word", acc_log[lb + 40].data, 32'hfc000000);

    // Reset in the middle of a dump.
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd0, 11'd9);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 1'b1, 10'd0, 11'd9);
    rst = 1'b1;
    repeat (2) @(negedge clk1);
    #1;
    checkResetState();
    rst = 1'b0;
    lb = acc_log.size();
    repeat (10) @(negedge clk1);
    checkOutput("post_rst_no_beats", 32'(acc_log.size() - lb), 0);

    // Start without HALTED, then a dump that wraps the memory window.
    applyStimulus(1'b1, 1'b0, 1'b1, 10'd0, 11'd4);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 11'd4);
    checkOutput("reject_err", 32'(err), 1);
    checkOutput("reject_busy", 32'(busy), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'd0, 11'd4);
    checkOutput("reject_err_cleared", 32'(err), 0);
    lb = acc_log.size();
    runDump(10'd1022, 11'd4, 2, cyc);
    checkOutput("wrap_beat_count", 32'(acc_log.size() - lb), 36);
    checkOutput("wrap_index0", 32'(acc_log[lb + 32].index), 1022);
    checkOutput("wrap_index1", 32'(acc_log[lb + 33].index), 1023);
    checkOutput("wrap_index2", 32'(acc_log[lb + 34].index), 0);
    checkOutput("wrap_index3", 32'(acc_log[lb + 35].index), 1);

    // Abort after ten accepted beats, then a full dump.
    lb = acc_log.size();
    applyStimulus(1'b1, 1'b1, 1'b1, 10'd0, 11'd9);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk1);
      #1;
      start = 1'b0;
      if (acc_log.size() - lb >= 10) break;
    end
    checkOutput("abort_ten_accepted", 32'(acc_log.size() - lb), 10);
    halted = 1'b0;
    @(negedge clk1);
    #1;
    checkOutput("abort_valid", 32'(out_valid), 0);
    checkOutput("abort_err", 32'(err), 1);
    checkOutput("abort_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 10'd0, 11'd9);
    lb = acc_log.size();
    runDump(10'd0, 11'd9, 2, cyc);
    checkOutput("after_abort_beats", 32'(acc_log.size() - lb), 41);

    // Randomized contents, windows and sink behaviour.
    for (int r = 0; r < 3; r++) begin
      logic [ADDR_W:0] len;
      logic [ADDR_W-1:0] base;
      for (int k = 0; k < REG_COUNT; k++) regs[k] = $urandom;
      for (int a = 0; a < MEM_DEPTH; a++) mem[a] = $urandom;
      base = ADDR_W'($urandom_range(0, MEM_DEPTH - 1));
      len = (r == 0) ? 11'($urandom_range(1, 40)) : (r == 1) ? 11'd0 : 11'd1024;
      lb = acc_log.size();
      runDump(base, len, 2, cyc);
      checkOutput("random_beat_count", 32'(acc_log.size() - lb), 32'(REG_COUNT + int'(len)));
    end

    repeat (3) @(negedge clk1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
